ref_burst_reader: RTL and testbench



---
 rtl/ref_burst_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_ref_burst_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ref_burst_reader
// Purpose  : Per-port read controller between a reference-segment consumer
//            and one reader port of the 4-port AXI arbiter. Takes one command
//            (start byte address + length in 256-bit beats) at a time. Splits
//            it into AXI bursts that never cross a 4 KB boundary and issues
//            them under an outstanding-burst credit limit. Returned beats are
//            passed straight through, and the final beat of the command is
//            marked.
// Ports    : clk, rst (sync, active-low)
//            cmd_*      : command handshake (addr, beats, valid/rdy)
//            rd_*_out   : burst request to arbiter (id, addr, len, valid)
//            rd_data_*  : beat return from arbiter (data, valid/rdy)
//            data_*     : forwarded beat stream to consumer (data, valid,
//                         last, rdy)
//            busy_out   : command in progress
// Revision : 1.0 - initial release
// ============================================================================
module ref_burst_reader #(
    parameter int PORT_TAG        = 0,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BEATS_WIDTH     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32:0]            cmd_addr_in,
    input  logic [BEATS_WIDTH-1:0] cmd_beats_in,
    input  logic                   cmd_valid_in,
    output logic                   cmd_rdy_out,
    output logic [ID_WIDTH-1:0]    rd_id_out,
    output logic [32:0]            rd_addr_out,
    output logic [7:0]             rd_len_out,
    output logic                   rd_info_valid_out,
    input  logic                   rd_info_rdy_in,
    input  logic [255:0]           rd_data_in,
    input  logic                   rd_data_valid_in,
    output logic                   rd_data_rdy_out,
    output logic [255:0]           data_out,
    output logic                   data_valid_out,
    output logic                   data_last_out,
    input  logic                   data_rdy_in,
    output logic                   busy_out
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Length FIFO is sized for the largest credit limit; pointers wrap
    // naturally and occupancy is bounded by the credit count.
    localparam int               c_FIFO_DEPTH  = 8;
    localparam logic [3:0]       c_MAX_OUT     = 4'(MAX_OUTSTANDING);
    localparam logic [7:0]       c_MAX_BURST   = 8'(MAX_BURST);
    localparam logic [BEATS_WIDTH-1:0] c_MAX_BURST_B = BEATS_WIDTH'(MAX_BURST);
    localparam logic [32:0]      c_ALIGN_MASK  = ~33'h1F;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [32:0]            r_addr;
    logic [BEATS_WIDTH-1:0] r_remaining;
    logic [3:0]             r_outstanding;
    logic [7:0]             r_fifo [c_FIFO_DEPTH];
    logic [2:0]             r_wr_ptr;
    logic [2:0]             r_rd_ptr;
    logic [7:0]             r_beat_cnt;

    logic [7:0]  w_boundary;
    logic [7:0]  w_nb_rem;
    logic [7:0]  w_nb;
    logic [7:0]  w_head;
    logic        w_has_out;
    logic        w_credit_ok;
    logic        w_cmd_fire;
    logic        w_req_fire;
    logic        w_beat_fire;
    logic        w_last_in_burst;
    logic        w_retire;
    logic        w_final_beat;
    logic        w_issue_done;

    // ------------------------------------------------------------------
    // Burst sizing: limited by what is left, the max burst, and the number
    // of 32-byte beats before the next 4 KB page.
    // ------------------------------------------------------------------
    assign w_boundary  = 8'd128 - {1'b0, r_addr[11:5]};
    assign w_nb_rem    = (r_remaining < c_MAX_BURST_B) ? r_remaining[7:0] : c_MAX_BURST;
    assign w_nb        = (w_nb_rem < w_boundary) ? w_nb_rem : w_boundary;
    assign w_issue_done = (r_remaining == BEATS_WIDTH'(w_nb));

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_has_out   = (r_outstanding != 4'd0);
    assign w_credit_ok = (r_outstanding < c_MAX_OUT);

    assign w_cmd_fire      = cmd_valid_in & cmd_rdy_out;
    assign w_req_fire      = rd_info_valid_out & rd_info_rdy_in;
    assign w_beat_fire     = rd_data_valid_in & rd_data_rdy_out;
    assign w_last_in_burst = (r_beat_cnt == (w_head - 8'd1));
    assign w_retire        = w_beat_fire & w_last_in_burst;
    // Last beat of the whole command: only one burst left and nothing more
    // to issue.
    assign w_final_beat    = (r_state == c_ST_DRAIN) & (r_outstanding == 4'd1) & w_last_in_burst;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A zero-length command is consumed without leaving IDLE.
                if (w_cmd_fire && (cmd_beats_in != '0)) begin
                    w_next_state = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (w_req_fire && w_issue_done) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_retire && w_final_beat) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything is forced low while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_rdy_out       = 1'b0;
        rd_info_valid_out = 1'b0;
        busy_out          = 1'b0;
        if (rst) begin
            cmd_rdy_out       = (r_state == c_ST_IDLE);
            rd_info_valid_out = (r_state == c_ST_ISSUE) & w_credit_ok;
            busy_out          = (r_state != c_ST_IDLE);
        end
    end

    // Request fields come straight from registers that only move on a
    // request handshake, so they hold steady while valid waits for ready.
    assign rd_id_out   = rst ? ID_WIDTH'(PORT_TAG) : '0;
    assign rd_addr_out = rst ? r_addr : '0;
    assign rd_len_out  = rst ? (w_nb - 8'd1) : '0;

    // Zero-latency pass-through; beats with no burst outstanding are
    // neither acknowledged nor forwarded.
    assign rd_data_rdy_out = rst & data_rdy_in & w_has_out;
    assign data_valid_out  = rst & rd_data_valid_in & w_has_out;
    assign data_out        = rst ? rd_data_in : '0;
    assign data_last_out   = rst & rd_data_valid_in & w_has_out & w_final_beat;

    // ------------------------------------------------------------------
    // Command / burst tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_beat_cnt    <= '0;
        end else begin
            if (w_cmd_fire && (cmd_beats_in != '0)) begin
                r_addr      <= cmd_addr_in & c_ALIGN_MASK;
                r_remaining <= cmd_beats_in;
            end else if (w_req_fire) begin
                r_addr      <= r_addr + (33'(w_nb) << 5);
                r_remaining <= r_remaining - BEATS_WIDTH'(w_nb);
            end

            if (w_req_fire) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end

            // Issue and retire in the same cycle cancel out.
            case ({w_req_fire, w_retire})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_retire) begin
                r_beat_cnt <= '0;
            end else if (w_beat_fire) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    // Length storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_fifo[r_wr_ptr] <= w_nb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ref_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ref_burst_reader
// Purpose  : Self-checking bench for ref_burst_reader. A table of commands
//            with hand-computed burst splits is replayed through a simple
//            arbiter/consumer model, followed by hand-written sequences for
//            credit limiting, backpressure, simultaneous issue/retire,
//            zero-length commands and reset during drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ref_burst_reader;

    logic         clk;
    logic         rst;
    logic [32:0]  cmd_addr_in;
    logic [23:0]  cmd_beats_in;
    logic         cmd_valid_in;
    logic         cmd_rdy_out;
    logic [3:0]   rd_id_out;
    logic [32:0]  rd_addr_out;
    logic [7:0]   rd_len_out;
    logic         rd_info_valid_out;
    logic         rd_info_rdy_in;
    logic [255:0] rd_data_in;
    logic         rd_data_valid_in;
    logic         rd_data_rdy_out;
    logic [255:0] data_out;
    logic         data_valid_out;
    logic         data_last_out;
    logic         data_rdy_in;
    logic         busy_out;

    int total = 0;
    int bad   = 0;

    ref_burst_reader #(
        .PORT_TAG(0), .ID_WIDTH(4), .MAX_BURST(16),
        .MAX_OUTSTANDING(4), .BEATS_WIDTH(24)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_addr_in(cmd_addr_in), .cmd_beats_in(cmd_beats_in),
        .cmd_valid_in(cmd_valid_in), .cmd_rdy_out(cmd_rdy_out),
        .rd_id_out(rd_id_out), .rd_addr_out(rd_addr_out),
        .rd_len_out(rd_len_out), .rd_info_valid_out(rd_info_valid_out),
        .rd_info_rdy_in(rd_info_rdy_in), .rd_data_in(rd_data_in),
        .rd_data_valid_in(rd_data_valid_in), .rd_data_rdy_out(rd_data_rdy_out),
        .data_out(data_out), .data_valid_out(data_valid_out),
        .data_last_out(data_last_out), .data_rdy_in(data_rdy_in),
        .busy_out(busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [32:0] addr;
        logic [23:0] beats;
        int          first_req;
        int          n_req;
    } cmd_vec_t;

    typedef struct {
        logic [32:0] addr;
        logic [7:0]  len;
    } req_vec_t;

    cmd_vec_t cmds [5];
    req_vec_t reqs [10];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] beat_pattern(input int ci, input int idx);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = 32'(ci * 65536 + idx * 8 + k) ^ 32'hC3A5_5A3C;
        end
        return w;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_rdy"},    256'(cmd_rdy_out),       256'd0);
        chk({tag, "_id"},         256'(rd_id_out),         256'd0);
        chk({tag, "_addr"},       256'(rd_addr_out),       256'd0);
        chk({tag, "_len"},        256'(rd_len_out),        256'd0);
        chk({tag, "_info_valid"}, 256'(rd_info_valid_out), 256'd0);
        chk({tag, "_data_rdy"},   256'(rd_data_rdy_out),   256'd0);
        chk({tag, "_data"},       data_out,                256'd0);
        chk({tag, "_data_valid"}, 256'(data_valid_out),    256'd0);
        chk({tag, "_last"},       256'(data_last_out),     256'd0);
        chk({tag, "_busy"},       256'(busy_out),          256'd0);
    endtask

    // Replays one table command with an arbiter that accepts every request
    // and returns owed beats back-to-back, and a consumer that stalls every
    // third cycle.
    task automatic run_cmd(input int ci);
        int nreq;
        int fwd;
        int pend;
        int add;
        int budget;
        int nbeats;
        nbeats = int'(cmds[ci].beats);
        next_cycle();
        cmd_addr_in      = cmds[ci].addr;
        cmd_beats_in     = cmds[ci].beats;
        cmd_valid_in     = 1'b1;
        rd_info_rdy_in   = 1'b1;
        rd_data_valid_in = 1'b0;
        data_rdy_in      = 1'b1;
        #1;
        chk("cmd_rdy_idle", 256'(cmd_rdy_out), 256'd1);
        next_cycle();
        cmd_valid_in = 1'b0;
        nreq = 0; fwd = 0; pend = 0; budget = 0;
        while (fwd < nbeats && budget < 600) begin
            rd_data_valid_in = (pend > 0);
            rd_data_in       = beat_pattern(ci, fwd);
            data_rdy_in      = ((budget % 3) != 2);
            #1;
            add = 0;
            if (rd_info_valid_out && rd_info_rdy_in) begin
                if (nreq < cmds[ci].n_req) begin
                    chk("req_addr", 256'(rd_addr_out), 256'(reqs[cmds[ci].first_req + nreq].addr));
                    chk("req_len",  256'(rd_len_out),  256'(reqs[cmds[ci].first_req + nreq].len));
                    chk("req_id",   256'(rd_id_out),   256'd0);
                    add = int'(reqs[cmds[ci].first_req + nreq].len) + 1;
                end else begin
                    chk("extra_req", 256'(nreq), 256'(cmds[ci].n_req));
                end
                nreq++;
            end
            if (pend > 0) begin
                chk("fwd_valid",    256'(data_valid_out),  256'd1);
                chk("beat_rdy",     256'(rd_data_rdy_out), 256'(data_rdy_in));
                if (data_rdy_in) begin
                    chk("fwd_data", data_out, rd_data_in);
                    chk("fwd_last", 256'(data_last_out), 256'(fwd == nbeats - 1));
                    fwd++;
                    pend--;
                end
            end
            pend += add;
            next_cycle();
            budget++;
        end
        if (budget >= 600) begin
            chk("cmd_timeout_beats", 256'(fwd), 256'(nbeats));
        end
        rd_data_valid_in = 1'b0;
        #1;
        chk("req_count",     256'(nreq),        256'(cmds[ci].n_req));
        chk("busy_after",    256'(busy_out),    256'd0);
        chk("cmd_rdy_after", 256'(cmd_rdy_out), 256'd1);
    endtask

    initial begin
        int nhs;
        int n;
        int nreq;

        // ---------------- vector tables ----------------
        cmds[0] = '{addr: 33'h0_0000_0000, beats: 24'd40, first_req: 0, n_req: 3};
        cmds[1] = '{addr: 33'h0_0000_0FC0, beats: 24'd8,  first_req: 3, n_req: 2};
        cmds[2] = '{addr: 33'h0_0000_001F, beats: 24'd1,  first_req: 5, n_req: 1};
        cmds[3] = '{addr: 33'h0_0000_0E20, beats: 24'd20, first_req: 6, n_req: 2};
        cmds[4] = '{addr: 33'h1_FFFF_FFE0, beats: 24'd3,  first_req: 8, n_req: 2};
        reqs[0] = '{addr: 33'h0_0000_0000, len: 8'd15};
        reqs[1] = '{addr: 33'h0_0000_0200, len: 8'd15};
        reqs[2] = '{addr: 33'h0_0000_0400, len: 8'd7};
        reqs[3] = '{addr: 33'h0_0000_0FC0, len: 8'd1};
        reqs[4] = '{addr: 33'h0_0000_1000, len: 8'd5};
        reqs[5] = '{addr: 33'h0_0000_0000, len: 8'd0};
        reqs[6] = '{addr: 33'h0_0000_0E20, len: 8'd14};
        reqs[7] = '{addr: 33'h0_0000_1000, len: 8'd4};
        reqs[8] = '{addr: 33'h1_FFFF_FFE0, len: 8'd0};
        reqs[9] = '{addr: 33'h0_0000_0000, len: 8'd1};

        // ---------------- reset ----------------
        rst              = 1'b0;
        cmd_addr_in      = 33'h0_0000_0400;
        cmd_beats_in     = 24'd5;
        cmd_valid_in     = 1'b1;
        rd_info_rdy_in   = 1'b1;
        rd_data_in       = beat_pattern(9, 9);
        rd_data_valid_in = 1'b1;
        data_rdy_in      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_init");
        rst          = 1'b1;
        cmd_valid_in = 1'b0;
        #1;
        chk("post_rst_cmd_rdy",    256'(cmd_rdy_out),       256'd1);
        chk("post_rst_busy",       256'(busy_out),          256'd0);
        chk("post_rst_info_valid", 256'(rd_info_valid_out), 256'd0);
        chk("post_rst_data_rdy",   256'(rd_data_rdy_out),   256'd0);
        chk("post_rst_data_valid", 256'(data_valid_out),    256'd0);

        // ---------------- zero-length command ----------------
        next_cycle();
        cmd_addr_in  = 33'h0_0000_0040;
        cmd_beats_in = 24'd0;
        cmd_valid_in = 1'b1;
        #1;
        chk("zero_cmd_rdy", 256'(cmd_rdy_out), 256'd1);
        next_cycle();
        cmd_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("zero_busy",       256'(busy_out),          256'd0);
            chk("zero_info_valid", 256'(rd_info_valid_out), 256'd0);
            chk("zero_cmd_rdy2",   256'(cmd_rdy_out),       256'd1);
            chk("zero_stray_rdy",  256'(rd_data_rdy_out),   256'd0);
            next_cycle();
        end
        rd_data_valid_in = 1'b0;

        // ---------------- table-driven commands ----------------
        for (int ci = 0; ci < 5; ci++) begin
            run_cmd(ci);
        end

        // ---------------- credit limit ----------------
        next_cycle();
        cmd_addr_in      = 33'h0_0000_0000;
        cmd_beats_in     = 24'd128;
        cmd_valid_in     = 1'b1;
        rd_info_rdy_in   = 1'b1;
        rd_data_valid_in = 1'b0;
        data_rdy_in      = 1'b1;
        next_cycle();
        cmd_valid_in = 1'b0;
        nhs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rd_info_valid_out && rd_info_rdy_in) nhs++;
            next_cycle();
        end
        #1;
        chk("credit_handshakes", 256'(nhs), 256'd4);
        chk("credit_blocked",    256'(rd_info_valid_out), 256'd0);
        rd_info_rdy_in   = 1'b0;
        rd_data_valid_in = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if (b == 15) begin
                #1;
                chk("credit_still_blocked", 256'(rd_info_valid_out), 256'd0);
            end
            next_cycle();
        end
        #1;
        chk("credit_fifth_valid", 256'(rd_info_valid_out), 256'd1);
        chk("credit_fifth_addr",  256'(rd_addr_out),       256'h800);
        chk("credit_fifth_len",   256'(rd_len_out),        256'd15);

        // ---------------- backpressure ----------------
        data_rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy_low",     256'(rd_data_rdy_out),   256'd0);
            chk("bp_fwd_valid",   256'(data_valid_out),    256'd1);
            chk("bp_req_held",    256'(rd_info_valid_out), 256'd1);
            chk("bp_addr_stable", 256'(rd_addr_out),       256'h800);
            next_cycle();
        end
        data_rdy_in = 1'b1;
        for (int i = 0; i < 15; i++) next_cycle();

        // ---------------- retire and issue in the same cycle ----------------
        rd_info_rdy_in = 1'b1;
        #1;
        chk("sim_req_valid", 256'(rd_info_valid_out), 256'd1);
        next_cycle();
        rd_data_valid_in = 1'b0;
        #1;
        chk("sim_credit_kept", 256'(rd_info_valid_out), 256'd1);
        chk("sim_next_addr",   256'(rd_addr_out),       256'hA00);
        next_cycle();
        rd_info_rdy_in = 1'b0;
        #1;
        chk("sim_credit_full", 256'(rd_info_valid_out), 256'd0);
        rd_data_valid_in = 1'b1;
        n = 0;
        do begin
            next_cycle();
            n++;
            #1;
        end while (!rd_info_valid_out && n < 40);
        chk("bp_burst_beats", 256'(n),           256'd16);
        chk("bp_next_addr",   256'(rd_addr_out), 256'hC00);

        // ---------------- run into DRAIN, then reset ----------------
        rd_info_rdy_in   = 1'b1;
        rd_data_valid_in = 1'b1;
        data_rdy_in      = 1'b1;
        nreq = 6;
        n    = 0;
        while (nreq < 8 && n < 200) begin
            if (rd_info_valid_out && rd_info_rdy_in) nreq++;
            next_cycle();
            #1;
            n++;
        end
        chk("drain_req_total",  256'(nreq),              256'd8);
        chk("drain_busy",       256'(busy_out),          256'd1);
        chk("drain_info_valid", 256'(rd_info_valid_out), 256'd0);
        rst          = 1'b0;
        cmd_valid_in = 1'b1;
        #1;
        chk_all_zero("rst_drain");
        next_cycle();
        #1;
        chk_all_zero("rst_drain_held");
        rst          = 1'b1;
        cmd_valid_in = 1'b0;
        #1;
        chk("rel_cmd_rdy",    256'(cmd_rdy_out),       256'd1);
        chk("rel_busy",       256'(busy_out),          256'd0);
        chk("rel_info_valid", 256'(rd_info_valid_out), 256'd0);
        chk("rel_data_rdy",   256'(rd_data_rdy_out),   256'd0);
        chk("rel_data_valid", 256'(data_valid_out),    256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
